zone_frame_writer: RTL
======================

// Module: zone_frame_writer
// PURPOSE
//  Frame-assembly stage upstream of the SRAM/SPI7001 LED driver path.
//  Collects one frame of per-zone dimming levels from the dimming algorithm
//  over a valid/ready stream and applies gamma and global gain. Emits the
//  frame as a contiguous write burst (sdbpflag pulse + wtaddr/wtdina) for
//  the driver frame RAM. Runs in the 25 MHz driver-write clock domain.
// PARAMETERS
//  NUM_LEDS   384   zones/LEDs per frame, one zone per LED, 2..1024
//  FRAME_GAP  4096  minimum cycles between successive O_sdbpflag pulses
//  GAMMA_EN   1     1: gray = level*level; 0: gray = {level,level}
// PORTS
//  I_clk          in   1   write-domain clock (25 MHz)
//  I_rst          in   1   async reset, active-high
//  I_gain         in   8   global brightness; scale = (I_gain+1)/256, sampled at START
//  I_zone_valid   in   1   zone level beat valid
//  I_zone_level   in   8   zone dimming level, 0..255
//  I_zone_last    in   1   last beat of the frame
//  O_zone_ready   out  1   block accepts a beat this cycle
//  O_sdbpflag     out  1   one-cycle frame-start pulse to the frame RAM
//  O_wten         out  1   O_wtaddr/O_wtdina valid this cycle
//  O_wtaddr       out  10  LED address, 0..NUM_LEDS-1
//  O_wtdina       out  16  LED gray value
//  O_frame_err    out  1   one-cycle pulse: I_zone_last not coincident with beat NUM_LEDS
// BEHAVIOUR
//  Reset: all outputs 0, state COLLECT, beat count 0, gap satisfied. Buffer RAM not cleared.
//  States: COLLECT -> WAIT_GAP -> START -> BURST -> COLLECT.
//  COLLECT: O_zone_ready=1. Beat accepted on valid&ready and stored at buffer[cnt]; cnt++.
//   Frame closes on the beat with I_zone_last=1 or on beat NUM_LEDS, whichever comes first.
//   Closing beat sets n_rx = beats received and leaves COLLECT next cycle (ready=0 from then).
//   Last before beat NUM_LEDS: O_frame_err pulse.
//   Beat NUM_LEDS without last: O_frame_err pulse. Any later beats up to
//   and including last are accepted and discarded in a DRAIN substate (ready=1); then WAIT_GAP.
//  WAIT_GAP: hold until >= FRAME_GAP cycles since previous O_sdbpflag; no wait for the first frame after reset.
//  START: O_sdbpflag=1 for exactly one cycle (cycle T); I_gain latched; O_wten=0.
//  BURST: O_wten=1 on cycles T+1..T+NUM_LEDS, contiguous, O_wtaddr = 0,1,..,NUM_LEDS-1.
//   Internal RAM read and multiply are pipelined (2 stages) and prefetched from START,
//   so there are no bubbles in the burst.
//   Addresses k >= n_rx (short frame) output O_wtdina=0.
//   Return to COLLECT the cycle after T+NUM_LEDS; cnt cleared.
//  Arithmetic: g = GAMMA_EN ? L*L : {L,L} (16b); O_wtdina = (g*(gain+1)) >> 8,
//   using a 25-bit product; result always <= 0xFFFF, no saturation needed.
//  When O_wten=0: O_wtaddr=0 and O_wtdina=0.
//  Gap counter saturates at FRAME_GAP.
//  Reset asserted mid-burst: outputs go 0 immediately; the partial frame is
//   abandoned; the next frame starts with a fresh O_sdbpflag.
//  Input beats are never accepted outside COLLECT/DRAIN; the driver stream is never stalled.
// TESTING
//  T1: NUM_LEDS=384, GAMMA_EN=1, gain=255, levels k%256 with last on beat 384
//   -> sdbpflag once; addr 0..383 contiguous; dina[k]=(k%256)^2; no err.
//  T2: gain=127, all levels 255 -> every dina = (65025*128)>>8 = 32512.
//  T3: last on beat 10 -> O_frame_err pulse; addr 0..9 carry data; addr 10..383 carry 0;
//   still 384 writes.
//  T4: 390 beats, last on beat 390 -> err pulse at beat 384; beats 385..390 dropped;
//   ready=0 after the DRAIN substate.
//  T5: two back-to-back frames with FRAME_GAP=4096 -> sdbpflag pulses exactly
//   >= 4096 cycles apart; ready stays 0 throughout BURST.
//  T6: I_rst asserted at burst addr 200 -> outputs 0 same cycle;
//   the next full frame writes addr 0..383 normally.

Source files
------------

// File: rtl/zone_frame_writer.sv
// Frame-assembly stage: collects one frame of zone levels, applies gamma and
// global gain, and emits a contiguous write burst to the LED driver frame RAM.
module zone_frame_writer #(
    parameter int unsigned NUM_LEDS  = 384,
    parameter int unsigned FRAME_GAP = 4096,
    parameter int unsigned GAMMA_EN  = 1
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic [7:0]  I_gain,
    input  logic        I_zone_valid,
    input  logic [7:0]  I_zone_level,
    input  logic        I_zone_last,
    output logic        O_zone_ready,
    output logic        O_sdbpflag,
    output logic        O_wten,
    output logic [9:0]  O_wtaddr,
    output logic [15:0] O_wtdina,
    output logic        O_frame_err
);

    localparam logic [2:0] ST_COLLECT  = 3'd0;
    localparam logic [2:0] ST_DRAIN    = 3'd1;
    localparam logic [2:0] ST_WAIT_GAP = 3'd2;
    localparam logic [2:0] ST_START    = 3'd3;
    localparam logic [2:0] ST_BURST    = 3'd4;

    localparam int unsigned CNT_W = $clog2(NUM_LEDS + 1);
    localparam int unsigned AW    = $clog2(NUM_LEDS);
    localparam int unsigned GAP_W = $clog2(FRAME_GAP + 1);
    localparam int unsigned DEPTH = 1 << AW;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_LEDS - 1);
    localparam logic [CNT_W-1:0] N_LEDS   = CNT_W'(NUM_LEDS);
    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(FRAME_GAP);
    localparam logic [GAP_W-1:0] GAP_GO   = GAP_W'(FRAME_GAP - 1);

    logic [2:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] n_rx;
    logic [CNT_W-1:0] rd_ptr;
    logic [GAP_W-1:0] gap_cnt;
    logic [7:0]       gain_q;
    logic [7:0]       buffer [DEPTH];

    logic             s1_valid;
    logic             s1_zero;
    logic [CNT_W-1:0] s1_addr;
    logic [7:0]       s1_level;

    logic             beat_c;
    logic             collect_beat_c;
    logic             close_c;
    logic             rd_en_c;
    logic [15:0]      gray_c;
    logic [8:0]       gain_p1_c;
    logic [24:0]      prod_c;
    logic [15:0]      dina_c;

    assign beat_c         = I_zone_valid & O_zone_ready &
                            ((state == ST_COLLECT) | (state == ST_DRAIN));
    assign collect_beat_c = beat_c & (state == ST_COLLECT);
    assign close_c        = I_zone_last | (cnt == LAST_IDX);

    // Read pointer runs one cycle ahead of START so address 0 lands on T+1.
    assign rd_en_c = (state_nxt == ST_START) |
                     (((state == ST_START) | (state == ST_BURST)) & (rd_ptr < N_LEDS));

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state <= ST_COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_COLLECT: begin
                if (collect_beat_c && close_c) begin
                    state_nxt = I_zone_last ? ST_WAIT_GAP : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (beat_c && I_zone_last) begin
                    state_nxt = ST_WAIT_GAP;
                end
            end
            ST_WAIT_GAP: begin
                if (gap_cnt >= GAP_GO) begin
                    state_nxt = ST_START;
                end
            end
            ST_START: state_nxt = ST_BURST;
            ST_BURST: begin
                if (cnt == LAST_IDX) begin
                    state_nxt = ST_COLLECT;
                end
            end
            default: state_nxt = ST_COLLECT;
        endcase
    end

    // Beat counter doubles as the burst cycle counter.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            cnt     <= '0;
            n_rx    <= '0;
            rd_ptr  <= '0;
            gap_cnt <= GAP_MAX;
            gain_q  <= '0;
        end else begin
            case (state)
                ST_COLLECT: begin
                    if (collect_beat_c) begin
                        cnt <= cnt + 1'b1;
                        if (close_c) begin
                            n_rx <= cnt + 1'b1;
                        end
                    end
                end
                ST_START: cnt <= '0;
                ST_BURST: cnt <= (state_nxt == ST_COLLECT) ? '0 : cnt + 1'b1;
                default: ;
            endcase

            if (rd_en_c) begin
                rd_ptr <= rd_ptr + 1'b1;
            end else if (state != ST_BURST) begin
                rd_ptr <= '0;
            end

            if (state == ST_START) begin
                gap_cnt <= GAP_W'(1);
            end else if (gap_cnt != GAP_MAX) begin
                gap_cnt <= gap_cnt + 1'b1;
            end

            if (state_nxt == ST_START) begin
                gain_q <= I_gain;
            end
        end
    end

    always_ff @(posedge I_clk) begin
        if (collect_beat_c) begin
            buffer[cnt[AW-1:0]] <= I_zone_level;
        end
        s1_level <= buffer[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            s1_valid <= 1'b0;
            s1_zero  <= 1'b0;
            s1_addr  <= '0;
        end else begin
            s1_valid <= rd_en_c;
            s1_zero  <= (rd_ptr >= n_rx);
            s1_addr  <= rd_ptr;
        end
    end

    always_comb begin
        gray_c = {s1_level, s1_level};
        if (GAMMA_EN != 0) begin
            gray_c = {8'd0, s1_level} * {8'd0, s1_level};
        end
        gain_p1_c = {1'b0, gain_q} + 9'd1;
        prod_c    = 25'(gray_c) * 25'(gain_p1_c);
        dina_c    = 16'(prod_c >> 8);
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            O_zone_ready <= 1'b0;
            O_sdbpflag   <= 1'b0;
            O_frame_err  <= 1'b0;
            O_wten       <= 1'b0;
            O_wtaddr     <= '0;
            O_wtdina     <= '0;
        end else begin
            O_zone_ready <= (state_nxt == ST_COLLECT) | (state_nxt == ST_DRAIN);
            O_sdbpflag   <= (state_nxt == ST_START);
            O_frame_err  <= collect_beat_c &
                            (I_zone_last ? (cnt != LAST_IDX) : (cnt == LAST_IDX));
            O_wten       <= s1_valid;
            O_wtaddr     <= s1_valid ? 10'(s1_addr) : 10'd0;
            O_wtdina     <= (s1_valid && !s1_zero) ? dina_c : 16'd0;
        end
    end

endmodule
